// File: rtl/frame_pipe_ctrl.sv
// Per-frame sequencer for the demosaic -> filter -> rgb2ycc pipeline.
// Optional FRAME_PIPE_CTRL_STATS_EN adds a per-frame cycle counter.
module frame_pipe_ctrl #(
  parameter int width         = 320,
  parameter int height        = 240,
  parameter int timeoutCycles = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        newFrame,
  input  logic        iValid,
  input  logic        iClrErr,
  input  logic        iDoneDemosaic,
  input  logic        iDoneFilter,
  input  logic        iDoneYcc,
  output logic [2:0]  oStageReset,
  output logic        oValidPix,
  output logic        oFlushEn,
  output logic        oBusy,
  output logic        oFrameDone,
  output logic [15:0] oFrameCnt,
  output logic        oOverrun,
  output logic        oTimeout,
  output logic [31:0] oLastFrameCycles
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [31:0] lastPix = 32'(width * height - 1);
  localparam logic [31:0] wdLast  = 32'(timeoutCycles - 1);

  state_t      state;
  logic [31:0] pixCnt;
  logic [31:0] wdCnt;
  logic        dnDem;
  logic        dnFil;
  logic        dnYcc;

  logic        accept;
  logic        allDone;
  logic        finish;
  logic        wdFire;
  logic        ovEvt;
  logic        inFrame;

  // Pixel gate and frame-level event decode
  always_comb begin
    inFrame   = (state == CAPTURE) || (state == DRAIN);
    oValidPix = iValid && (state == CAPTURE);
    accept    = newFrame && ((state == IDLE) || (state == DONE));
    allDone   = (dnDem || iDoneDemosaic) &&
                (dnFil || iDoneFilter) &&
                (dnYcc || iDoneYcc);
    finish    = (state == DRAIN) && allDone;
    wdFire    = (state == DRAIN) && !allDone && (wdCnt == wdLast);
    ovEvt     = newFrame && inFrame;
  end

  // Main sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pixCnt      <= '0;
      wdCnt       <= '0;
      dnDem       <= 1'b0;
      dnFil       <= 1'b0;
      dnYcc       <= 1'b0;
      oStageReset <= 3'b000;
      oFlushEn    <= 1'b0;
      oBusy       <= 1'b0;
      oFrameDone  <= 1'b0;
      oFrameCnt   <= '0;
      oOverrun    <= 1'b0;
      oTimeout    <= 1'b0;
    end else begin
      oStageReset <= 3'b000;
      oFrameDone  <= 1'b0;

      if (ovEvt) begin
        oOverrun <= 1'b1;
      end else if (iClrErr) begin
        oOverrun <= 1'b0;
      end

      if (wdFire) begin
        oTimeout <= 1'b1;
      end else if (iClrErr) begin
        oTimeout <= 1'b0;
      end

      unique case (state)
        IDLE, DONE: begin
          oFlushEn <= 1'b0;
          if (accept) begin
            state       <= CAPTURE;
            oBusy       <= 1'b1;
            oStageReset <= 3'b111;
            pixCnt      <= '0;
            dnDem       <= 1'b0;
            dnFil       <= 1'b0;
            dnYcc       <= 1'b0;
          end else begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
        end
        CAPTURE: begin
          dnDem <= dnDem || iDoneDemosaic;
          dnFil <= dnFil || iDoneFilter;
          dnYcc <= dnYcc || iDoneYcc;
          if (oValidPix) begin
            if (pixCnt == lastPix) begin
              state    <= DRAIN;
              pixCnt   <= '0;
              wdCnt    <= '0;
              oFlushEn <= 1'b1;
            end else begin
              pixCnt <= pixCnt + 32'd1;
            end
          end
        end
        DRAIN: begin
          dnDem <= dnDem || iDoneDemosaic;
          dnFil <= dnFil || iDoneFilter;
          dnYcc <= dnYcc || iDoneYcc;
          wdCnt <= wdCnt + 32'd1;
          if (finish) begin
            state      <= DONE;
            oFlushEn   <= 1'b0;
            oFrameDone <= 1'b1;
            oFrameCnt  <= oFrameCnt + 16'd1;
          end else if (wdFire) begin
            state       <= IDLE;
            oFlushEn    <= 1'b0;
            oBusy       <= 1'b0;
            oStageReset <= 3'b111;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_PIPE_CTRL_STATS_EN
  logic [31:0] cycCnt;

  // Frame cycle counter; result includes the DONE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cycCnt           <= '0;
      oLastFrameCycles <= '0;
    end else begin
      if (accept) begin
        cycCnt <= '0;
      end else if (inFrame) begin
        cycCnt <= cycCnt + 32'd1;
      end
      if (finish) begin
        oLastFrameCycles <= cycCnt + 32'd2;
      end
    end
  end
`else
  assign oLastFrameCycles = '0;
`endif

endmodule

// File: tb/tb_frame_pipe_ctrl.sv
// Directed bench for frame_pipe_ctrl.
// Small frame geometry, hand-computed expectations.
module tb_frame_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic        newFrame;
  logic        iValid;
  logic        iClrErr;
  logic        iDoneDemosaic;
  logic        iDoneFilter;
  logic        iDoneYcc;
  logic [2:0]  oStageReset;
  logic        oValidPix;
  logic        oFlushEn;
  logic        oBusy;
  logic        oFrameDone;
  logic [15:0] oFrameCnt;
  logic        oOverrun;
  logic        oTimeout;
  logic [31:0] oLastFrameCycles;

  int nChecks = 0;
  int nFails  = 0;
  int vpCnt, srCnt, flCnt, fdCnt;

  frame_pipe_ctrl #(
    .width(4),
    .height(2),
    .timeoutCycles(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .newFrame(newFrame),
    .iValid(iValid),
    .iClrErr(iClrErr),
    .iDoneDemosaic(iDoneDemosaic),
    .iDoneFilter(iDoneFilter),
    .iDoneYcc(iDoneYcc),
    .oStageReset(oStageReset),
    .oValidPix(oValidPix),
    .oFlushEn(oFlushEn),
    .oBusy(oBusy),
    .oFrameDone(oFrameDone),
    .oFrameCnt(oFrameCnt),
    .oOverrun(oOverrun),
    .oTimeout(oTimeout),
    .oLastFrameCycles(oLastFrameCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clrCnt;
    vpCnt = 0;
    srCnt = 0;
    flCnt = 0;
    fdCnt = 0;
  endtask

  task automatic tick;
    #1;
    vpCnt += int'(oValidPix);
    if (oStageReset == 3'b111) srCnt++;
    flCnt += int'(oFlushEn);
    fdCnt += int'(oFrameDone);
    @(posedge clk);
    #1;
  endtask

  task automatic pix;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
  endtask

  task automatic startFrame;
    newFrame = 1'b1;
    tick();
    newFrame = 1'b0;
  endtask

  task automatic allDones;
    iDoneDemosaic = 1'b1;
    iDoneFilter   = 1'b1;
    iDoneYcc      = 1'b1;
    tick();
    iDoneDemosaic = 1'b0;
    iDoneFilter   = 1'b0;
    iDoneYcc      = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    newFrame      = 1'b0;
    iValid        = 1'b0;
    iClrErr       = 1'b0;
    iDoneDemosaic = 1'b0;
    iDoneFilter   = 1'b0;
    iDoneYcc      = 1'b0;
    clrCnt();
    @(posedge clk);
    #1;
    tick();
    tick();
    check("rst_busy", 32'(oBusy), 0);
    check("rst_sr", 32'(oStageReset), 0);
    check("rst_cnt", 32'(oFrameCnt), 0);
    check("rst_flags", 32'({oOverrun, oTimeout, oFrameDone, oFlushEn}), 0);
    reset = 1'b0;
    tick();

    // 1: contiguous frame, dones on separate cycles
    clrCnt();
    startFrame();
    for (int i = 0; i < 8; i++) pix();
    iDoneDemosaic = 1'b1; tick(); iDoneDemosaic = 1'b0;
    iDoneFilter   = 1'b1; tick(); iDoneFilter   = 1'b0;
    check("t1_busy_drain", 32'(oBusy), 1);
    iDoneYcc      = 1'b1; tick(); iDoneYcc      = 1'b0;
    check("t1_done_pulse", 32'(oFrameDone), 1);
    check("t1_flush_done", 32'(oFlushEn), 0);
    tick();
    check("t1_sr_cycles", 32'(srCnt), 1);
    check("t1_vp_cycles", 32'(vpCnt), 8);
    check("t1_fl_cycles", 32'(flCnt), 3);
    check("t1_fd_cycles", 32'(fdCnt), 1);
    check("t1_cnt", 32'(oFrameCnt), 1);
    check("t1_idle", 32'(oBusy), 0);
    iValid = 1'b1;
    #1;
    check("t1_idle_drop", 32'(oValidPix), 0);
    iValid = 1'b0;

    // 2: gapped pixels and extras in DRAIN
    clrCnt();
    startFrame();
    for (int i = 0; i < 8; i++) begin
      pix();
      tick();
      tick();
    end
    iValid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    iValid = 1'b0;
    allDones();
    tick();
    check("t2_vp_cycles", 32'(vpCnt), 8);
    check("t2_fd_cycles", 32'(fdCnt), 1);
    check("t2_cnt", 32'(oFrameCnt), 2);

    // 3: missing ycc done -> watchdog
    clrCnt();
    startFrame();
    for (int i = 0; i < 8; i++) pix();
    iDoneDemosaic = 1'b1; tick(); iDoneDemosaic = 1'b0;
    iDoneFilter   = 1'b1; tick(); iDoneFilter   = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    check("t3_no_to_early", 32'(oTimeout), 0);
    tick();
    check("t3_timeout", 32'(oTimeout), 1);
    check("t3_sr", 32'(oStageReset), 32'h7);
    check("t3_idle", 32'(oBusy), 0);
    check("t3_cnt", 32'(oFrameCnt), 2);
    tick();
    check("t3_fd_cycles", 32'(fdCnt), 0);
    check("t3_sr_drop", 32'(oStageReset), 0);
    iClrErr = 1'b1; tick(); iClrErr = 1'b0;
    check("t3_clr", 32'(oTimeout), 0);

    // 3b: last done on the watchdog cycle wins
    startFrame();
    for (int i = 0; i < 8; i++) pix();
    iDoneDemosaic = 1'b1;
    iDoneFilter   = 1'b1;
    tick();
    iDoneDemosaic = 1'b0;
    iDoneFilter   = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    iDoneYcc = 1'b1; tick(); iDoneYcc = 1'b0;
    check("t3b_done", 32'(oFrameDone), 1);
    check("t3b_no_to", 32'(oTimeout), 0);
    check("t3b_cnt", 32'(oFrameCnt), 3);
    tick();

    // 4: overrun mid-capture, newFrame in DONE
    clrCnt();
    startFrame();
    for (int i = 0; i < 8; i++) begin
      newFrame = (i == 3);
      pix();
    end
    newFrame = 1'b0;
    check("t4_overrun", 32'(oOverrun), 1);
    iClrErr = 1'b1;
    allDones();
    iClrErr = 1'b0;
    check("t4_done", 32'(oFrameDone), 1);
    check("t4_ov_clr", 32'(oOverrun), 0);
    check("t4_vp_cycles", 32'(vpCnt), 8);
    startFrame();
    check("t4_rearm_busy", 32'(oBusy), 1);
    check("t4_rearm_sr", 32'(oStageReset), 32'h7);
    check("t4_no_ov", 32'(oOverrun), 0);
    check("t4_cnt", 32'(oFrameCnt), 4);
    for (int i = 0; i < 7; i++) pix();
    iDoneDemosaic = 1'b1;
    pix();
    iDoneDemosaic = 1'b0;
    check("t4_flush", 32'(oFlushEn), 1);
    iDoneFilter = 1'b1;
    iDoneYcc    = 1'b1;
    tick();
    iDoneFilter = 1'b0;
    iDoneYcc    = 1'b0;
    check("t4_edge_done", 32'(oFrameDone), 1);
    check("t4_cnt2", 32'(oFrameCnt), 5);
    tick();

    // 5: frame counter wrap, then reset during DRAIN
    force dut.oFrameCnt = 16'hFFFF;
    tick();
    release dut.oFrameCnt;
    tick();
    check("t5_forced", 32'(oFrameCnt), 32'hFFFF);
    startFrame();
    for (int i = 0; i < 8; i++) pix();
    allDones();
    check("t5_wrap", 32'(oFrameCnt), 0);
    tick();
    startFrame();
    for (int i = 0; i < 8; i++) pix();
    tick();
    reset = 1'b1;
    allDones();
    check("t5_rst_busy", 32'(oBusy), 0);
    check("t5_rst_flush", 32'(oFlushEn), 0);
    check("t5_rst_fd", 32'(oFrameDone), 0);
    tick();
    reset = 1'b0;
    tick();

    // 6: cycle statistics
    check("t6_stats_rst", oLastFrameCycles, 0);
    startFrame();
    for (int i = 0; i < 8; i++) pix();
    tick();
    tick();
    allDones();
    check("t6_done", 32'(oFrameDone), 1);
    check("t6_cnt", 32'(oFrameCnt), 1);
`ifdef FRAME_PIPE_CTRL_STATS_EN
    check("t6_stats", oLastFrameCycles, 12);
`else
    check("t6_stats", oLastFrameCycles, 0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/frame_pipe_ctrl.md
Name: frame_pipe_ctrl

Overview:
- Per-frame sequencer for the pixel pipeline: demosaic, then kernel filter, then rgb2ycc.
- Arms the pipeline on newFrame, clears the stages, and gates sensor pixels into demosaic for exactly one frame.
- Holds the filter flush-enable until every stage reports done, then signals frame completion.
- Detects frame overrun and stage hang (watchdog). Sits between the sensor front end and the processing top level.

Parameters:
- width, 320, pixels per row
- height, 240, rows per frame
- timeoutCycles, 200000, maximum DRAIN cycles before the watchdog aborts the frame

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- newFrame  in  1  start-of-frame pulse from the sensor
- iValid  in  1  sensor pixel valid
- iClrErr  in  1  clears the sticky oOverrun and oTimeout
- iDoneDemosaic  in  1  demosaic done pulse
- iDoneFilter  in  1  filter done pulse
- iDoneYcc  in  1  rgb2ycc done pulse
- oStageReset  out  3  per-stage clear {ycc, filter, demosaic}; OR'ed into each stage's reset
- oValidPix  out  1  iValid gated for the current frame; drives demosaic iValid
- oFlushEn  out  1  keeps the filter pipeline stepping after input ends
- oBusy  out  1  state is not IDLE
- oFrameDone  out  1  one-cycle pulse on successful frame completion
- oFrameCnt  out  16  completed-frame count; wraps 0xFFFF to 0
- oOverrun  out  1  sticky: newFrame arrived while busy
- oTimeout  out  1  sticky: watchdog fired
- oLastFrameCycles  out  32  see Optional Feature

Behaviour:
- Reset values: state IDLE; all outputs 0; pixCnt = 0, wdCnt = 0, done latches = 0.
- oValidPix = iValid & (state==CAPTURE). Combinational, zero latency. All other outputs are registered.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE:
  - newFrame -> CAPTURE.
  - In the same edge: oStageReset <= 3'b111 for exactly one cycle; pixCnt and done latches cleared.
  - iValid in IDLE is dropped.
- CAPTURE:
  - pixCnt increments on oValidPix.
  - When oValidPix is high with pixCnt == width*height-1 -> DRAIN, pixCnt <= 0, wdCnt <= 0.
  - The pixel in that cycle is passed through.
- DRAIN:
  - oFlushEn = 1; oValidPix = 0 (extra sensor pixels are dropped).
  - wdCnt increments each cycle.
  - All three done latches set -> DONE.
  - Otherwise, wdCnt == timeoutCycles-1 -> oTimeout <= 1, oStageReset <= 3'b111 for one cycle, -> IDLE. No oFrameDone; oFrameCnt unchanged.
- DONE (one cycle):
  - oFrameDone = 1, oFrameCnt += 1, oFlushEn = 0.
  - Next state IDLE.
  - If newFrame is high in DONE, it is accepted exactly as in IDLE (-> CAPTURE with stage reset). It is not an overrun.
- Done latches:
  - Each iDone* sets its latch during CAPTURE or DRAIN. Pulses in IDLE/DONE are ignored.
  - A done pulse in the same cycle as the CAPTURE->DRAIN transition is latched.
  - A done pulse in the same cycle the watchdog fires: the done-complete check wins (-> DONE), and the timeout is not flagged.
- Overrun:
  - newFrame in CAPTURE or DRAIN sets oOverrun.
  - The request is ignored; the current frame continues.
- iClrErr clears oOverrun and oTimeout. If iClrErr and a new error event occur in the same cycle, the set wins.
- Width rules: pixCnt is 32-bit; wdCnt is 32-bit; compares are unsigned.
- A reset asserted mid-frame forces IDLE in the next cycle with every output at its reset value. No oFrameDone is emitted.

Optional Feature:
- Macro: FRAME_PIPE_CTRL_STATS_EN.
- Defined:
  - A 32-bit cycle counter clears on entry to CAPTURE and increments every cycle in CAPTURE and DRAIN.
  - On entering DONE, oLastFrameCycles <= counter + 1 (inclusive of the DONE cycle).
  - The value holds until the next successful frame. A timed-out frame does not update it.
- Undefined: oLastFrameCycles is tied to 0 and no counter is synthesized.

Test Plan (width=4, height=2, timeoutCycles=16):
1. Reset, newFrame, then 8 contiguous iValid, then iDoneDemosaic, iDoneFilter, iDoneYcc on separate cycles -> oStageReset=3'b111 for 1 cycle; oValidPix exactly 8 cycles; oFlushEn high from pixel 9 until the DONE cycle; oFrameDone pulses once; oFrameCnt=1.
2. iValid gapped (1 of every 3 cycles) plus 4 extra pixels after the 8th -> oValidPix exactly 8 high cycles; extras dropped in DRAIN.
3. In DRAIN, only iDoneDemosaic and iDoneFilter arrive -> after 16 DRAIN cycles oTimeout=1, oStageReset pulse, IDLE, oFrameCnt unchanged; iClrErr -> oTimeout=0.
4. newFrame mid-CAPTURE (pixel 3) -> oOverrun=1; frame still completes with 8 pixels and oFrameDone; newFrame in the DONE cycle -> CAPTURE immediately and oOverrun is not set again.
5. Force oFrameCnt to 0xFFFF, complete a frame -> oFrameCnt=0; assert reset during DRAIN -> next cycle oBusy=0, oFlushEn=0, no oFrameDone.
6. With FRAME_PIPE_CTRL_STATS_EN, 8 contiguous pixels and all dones on DRAIN cycle 3 -> oLastFrameCycles=12 (8 CAPTURE + 3 DRAIN + 1 DONE); without the macro, oLastFrameCycles=0 throughout.
